// File: rtl/instruction_fetch_memory_if.sv
// Load / fetch-request / fetch-response bundle for instruction_fetch_memory.
// The master side loads programs and issues fetches. The slave side is the memory.
interface instruction_fetch_memory_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_parity_flip;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_instruct;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_addr_err;
  logic                  rsp_parity_err;
  logic                  busy;

  modport master (
    output load_en, load_addr, load_data, load_parity_flip, req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instruct, rsp_addr, rsp_addr_err, rsp_parity_err, busy
  );

  modport slave (
    input  load_en, load_addr, load_data, load_parity_flip, req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instruct, rsp_addr, rsp_addr_err, rsp_parity_err, busy
  );
endinterface

// File: rtl/instruction_fetch_memory.sv
// Instruction memory with a fixed-latency read pipeline feeding an in-order response queue.
// Define IMEM_PARITY_EN to store and check an even-parity bit per word.
module instruction_fetch_memory #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int MEM_DEPTH    = 256,
  parameter int READ_LATENCY = 2,
  parameter int QUEUE_DEPTH  = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  instruction_fetch_memory_if.slave bus
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
  localparam int ENT_W = DATA_WIDTH + ADDR_WIDTH + 2;
`else
  localparam int MEM_W = DATA_WIDTH;
  localparam int ENT_W = DATA_WIDTH + ADDR_WIDTH + 1;
`endif

  logic [MEM_W-1:0]      mem [MEM_DEPTH];
  logic [MEM_W-1:0]      load_word;
  logic                  load_ok;
  logic                  req_oob;
  logic                  accept;
  logic                  deq;
  logic                  enq;
  logic                  rdy_en_q;
  logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]      q_cnt_q, q_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  s0_vld_q;
  logic [MEM_W-1:0]      s0_word_q;
  logic [ADDR_WIDTH-1:0] s0_addr_q;
  logic                  s0_aerr_q;
  logic [DATA_WIDTH-1:0] s0_data;
  logic [ENT_W-1:0]      pipe_ent [READ_LATENCY];
  logic                  pipe_vld [READ_LATENCY];
  logic [ENT_W-1:0]      q_mem [QUEUE_DEPTH];
  logic [ENT_W-1:0]      head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign load_ok = bus.load_en && ({1'b0, bus.load_addr} < DEPTH_LIM);
  assign req_oob = ({1'b0, bus.req_addr} >= DEPTH_LIM);
`ifdef IMEM_PARITY_EN
  assign load_word = {(^bus.load_data) ^ bus.load_parity_flip, bus.load_data};
`else
  assign load_word = bus.load_data;
`endif

  // rdy_en_q keeps req_ready low throughout reset and until the first clean edge
  assign bus.req_ready = rdy_en_q && (out_cnt_q < CNT_W'(QUEUE_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = (q_cnt_q != '0);
  assign deq           = bus.rsp_valid && bus.rsp_ready;
  assign bus.busy      = (out_cnt_q != '0);

  // Read and write share one edge; nonblocking semantics give read-first behaviour
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[bus.load_addr[IDX_W-1:0]] <= load_word;
    end
    if (accept) begin
      s0_word_q <= mem[bus.req_addr[IDX_W-1:0]];
      s0_addr_q <= bus.req_addr;
      s0_aerr_q <= req_oob;
    end
  end

  assign s0_data = s0_aerr_q ? '0 : s0_word_q[DATA_WIDTH-1:0];
`ifdef IMEM_PARITY_EN
  assign pipe_ent[0] = {!s0_aerr_q && (^s0_word_q), s0_aerr_q, s0_addr_q, s0_data};
`else
  assign pipe_ent[0] = {s0_aerr_q, s0_addr_q, s0_data};
`endif
  assign pipe_vld[0] = s0_vld_q;

  generate
    for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
      logic             vld_q;
      logic [ENT_W-1:0] ent_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
        end else begin
          vld_q <= pipe_vld[gi-1];
        end
      end

      always_ff @(posedge clk) begin
        ent_q <= pipe_ent[gi-1];
      end

      assign pipe_vld[gi] = vld_q;
      assign pipe_ent[gi] = ent_q;
    end
  endgenerate

  assign enq = pipe_vld[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (enq) begin
      q_mem[wr_ptr_q] <= pipe_ent[READ_LATENCY-1];
    end
  end

  assign head = q_mem[rd_ptr_q];
  assign bus.rsp_instruct = bus.rsp_valid ? head[DATA_WIDTH-1:0] : '0;
  assign bus.rsp_addr     = bus.rsp_valid ? head[DATA_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.rsp_addr_err = bus.rsp_valid && head[DATA_WIDTH+ADDR_WIDTH];
`ifdef IMEM_PARITY_EN
  assign bus.rsp_parity_err = bus.rsp_valid && head[ENT_W-1];
`else
  assign bus.rsp_parity_err = 1'b0;
`endif

  always_comb begin
    out_cnt_d = out_cnt_q;
    q_cnt_d   = q_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (accept && !deq) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end else if (!accept && deq) begin
      out_cnt_d = out_cnt_q - CNT_W'(1);
    end
    if (enq && !deq) begin
      q_cnt_d = q_cnt_q + CNT_W'(1);
    end else if (!enq && deq) begin
      q_cnt_d = q_cnt_q - CNT_W'(1);
    end
    if (enq) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (deq) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q  <= 1'b0;
      out_cnt_q <= '0;
      q_cnt_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      s0_vld_q  <= 1'b0;
    end else begin
      rdy_en_q  <= 1'b1;
      out_cnt_q <= out_cnt_d;
      q_cnt_q   <= q_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      s0_vld_q  <= accept;
    end
  end

endmodule
